sc_port_display: RTL and testbench

- Downstream consumer of the data memory's memory-mapped output port `out_port0`. It lives in the computer top level, beside the CPU/imem/dmem trio.
- Converts the 32-bit binary port value to decimal with a sequential double-dabble engine.
- Drives NUM_DIGITS active-low seven-segment digits.
- The display changes only on conversion completion, so it never shows a half-converted value.

---
 rtl/sc_port_display.sv | 147 ++++++++++++++
 tb/tb_sc_port_display.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_port_display.sv
// Converts the dmem output port value to decimal using a sequential
// double-dabble engine and drives active-low seven-segment digits.
// Optional leading-zero blanking: define SC_PORT_DISPLAY_BLANK_EN.
module sc_port_display #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       port_in,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    update,
  output logic                    overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LATCH} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [DATA_W-1:0]         r_shadow;
  logic [DATA_W-1:0]         r_bin;
  logic [BCD_W-1:0]          r_bcd;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_ovf_acc;
  logic [7*NUM_DIGITS-1:0]   r_hex;
  logic                      r_update;
  logic                      r_overflow;
  logic [BCD_W-1:0]          w_bcd_adj;
  logic                      w_capture;
  logic                      w_last;

  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  // Builds the whole display word; overflow dashes take priority over blanking.
  function automatic logic [7*NUM_DIGITS-1:0] f_display(input logic [BCD_W-1:0] bcd,
                                                        input logic ovf);
    logic [3:0] nib;
`ifdef SC_PORT_DISPLAY_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    f_display = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = bcd[4*k +: 4];
      if (ovf) begin
        f_display[7*k +: 7] = 7'b0111111;
      end else begin
        f_display[7*k +: 7] = f_seg(nib);
`ifdef SC_PORT_DISPLAY_BLANK_EN
        if (lead && (nib == 4'd0) && (k != 0)) f_display[7*k +: 7] = 7'b1111111;
        if (nib != 4'd0) lead = 1'b0;
`endif
      end
    end
  endfunction

  assign w_capture = (port_in != r_shadow);
  assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_capture) w_next = S_CONVERT;
      S_CONVERT: if (w_last) w_next = S_LATCH;
      S_LATCH:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Control and visible outputs: reset aborts any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow   <= '0;
      r_ovf_acc  <= 1'b0;
      r_hex      <= f_display('0, 1'b0);
      r_update   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_shadow  <= port_in;
            r_ovf_acc <= 1'b0;
          end
        end
        S_CONVERT: begin
          if (w_bcd_adj[BCD_W-1]) r_ovf_acc <= 1'b1;
        end
        S_LATCH: begin
          r_hex      <= f_display(r_bcd, r_ovf_acc);
          r_overflow <= r_ovf_acc;
          r_update   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Shift datapath is always initialised on capture, so it needs no reset.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && w_capture) begin
      r_bin <= port_in;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == S_CONVERT) begin
      {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + 1'b1;
    end
  end

  assign hex_out  = r_hex;
  assign busy     = (r_state != S_IDLE);
  assign update   = r_update;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_sc_port_display.sv
// Self-checking bench for sc_port_display: randomized values against a
// divide-and-modulo decimal model, plus timing, overflow and reset scenarios.
module tb_sc_port_display;

  localparam int DATA_W     = 32;
  localparam int NUM_DIGITS = 6;

  logic                    clock;
  logic                    reset;
  logic [DATA_W-1:0]       port_in;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    busy;
  logic                    update;
  logic                    overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  sc_port_display #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) dut (
    .clock   (clock),
    .reset   (reset),
    .port_in (port_in),
    .hex_out (hex_out),
    .busy    (busy),
    .update  (update),
    .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (update === 1'b1) upd_cnt++;

  function automatic longint pow10(input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic exp_ovf(input longint v);
    return v >= pow10(NUM_DIGITS);
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] exp_hex(input longint v);
    logic [7*NUM_DIGITS-1:0] h;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (exp_ovf(v)) h[7*k +: 7] = 7'b0111111;
      else            h[7*k +: 7] = SEG[int'((v / pow10(k)) % 10)];
`ifdef SC_PORT_DISPLAY_BLANK_EN
      if (!exp_ovf(v) && k > 0 && v < pow10(k)) h[7*k +: 7] = 7'b1111111;
`endif
    end
    return h;
  endfunction

  // Advances clock edges until update is seen (sampled 1ns after each edge), max 100.
  task automatic wait_upd(output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (update !== 1'b1 && n < 100);
  endtask

  task automatic test_reset();
    reset = 1'b1; port_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    n_tests++;
    if (hex_out !== exp_hex(0) || busy !== 1'b0 || update !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hex=%h busy=%b upd=%b ovf=%b, expected hex=%h 0 0 0",
               hex_out, busy, update, overflow, exp_hex(0));
    end
    repeat (40) @(posedge clock);
    #1;
    n_tests++;
    if (upd_cnt !== 0 || busy !== 1'b0 || hex_out !== exp_hex(0)) begin
      n_fail++;
      $display("FAIL zero_no_convert: updates=%0d busy=%b hex=%h, expected 0 0 %h",
               upd_cnt, busy, hex_out, exp_hex(0));
    end
  endtask

  task automatic test_convert_timing();
    int n;
    int u0;
    u0 = upd_cnt;
    port_in = 32'd123456;
    @(posedge clock); #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_rise: busy=%b, expected 1", busy);
    end
    wait_upd(n);
    n_tests++;
    if (n !== 33) begin
      n_fail++; $display("FAIL latency_123456: edges=%0d, expected 33", n);
    end
    n_tests++;
    if (hex_out !== exp_hex(123456) || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL value_123456: hex=%h ovf=%b busy=%b, expected hex=%h 0 0",
               hex_out, overflow, busy, exp_hex(123456));
    end
    n_tests++;
    if (hex_out[6:0] !== 7'b0000010) begin
      n_fail++; $display("FAIL digit0_six: seg=%b, expected 0000010", hex_out[6:0]);
    end
    repeat (40) @(posedge clock);
    #1;
    n_tests++;
    if (upd_cnt - u0 !== 1) begin
      n_fail++; $display("FAIL hold_no_spurious: updates=%0d, expected 1", upd_cnt - u0);
    end
  endtask

  task automatic convert_and_check(input longint v, input string name);
    int n;
    port_in = DATA_W'(v);
    wait_upd(n);
    n_tests++;
    if (n !== 34 || hex_out !== exp_hex(v) || overflow !== exp_ovf(v)) begin
      n_fail++;
      $display("FAIL %s: edges=%0d hex=%h ovf=%b, expected edges=34 hex=%h ovf=%b",
               name, n, hex_out, overflow, exp_hex(v), exp_ovf(v));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_overflow();
    convert_and_check(64'hFFFFFFFF, "ovf_max");
    convert_and_check(42, "after_ovf_42");
    convert_and_check(999999, "max_in_range");
    convert_and_check(1000000, "ovf_boundary");
    convert_and_check(0, "after_ovf_zero");
  endtask

  task automatic test_random();
    longint v;
    longint prev;
    prev = longint'(port_in);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) v = longint'($urandom_range(0, 999999));
      else            v = longint'($urandom);
      if (v == prev) v = (v + 1) % 64'h100000000;
      convert_and_check(v, $sformatf("random_%0d", i));
      prev = v;
    end
  endtask

  task automatic test_busy_changes();
    int n;
    int u0;
    u0 = upd_cnt;
    port_in = 32'd5;
    @(posedge clock); #1;
    repeat (10) @(posedge clock);
    port_in = 32'd7;
    repeat (10) @(posedge clock);
    port_in = 32'd9;
    wait_upd(n);
    n_tests++;
    if (n !== 13 || hex_out !== exp_hex(5)) begin
      n_fail++;
      $display("FAIL busy_first_5: edges=%0d hex=%h, expected 13 %h", n, hex_out, exp_hex(5));
    end
    wait_upd(n);
    n_tests++;
    if (n !== 34 || hex_out !== exp_hex(9)) begin
      n_fail++;
      $display("FAIL busy_newest_9: edges=%0d hex=%h, expected 34 %h", n, hex_out, exp_hex(9));
    end
    repeat (40) @(posedge clock);
    #1;
    n_tests++;
    if (upd_cnt - u0 !== 2) begin
      n_fail++; $display("FAIL busy_two_updates: updates=%0d, expected 2", upd_cnt - u0);
    end
  endtask

  task automatic test_reset_midconv();
    int n;
    port_in = 32'd777;
    @(posedge clock); #1;
    repeat (15) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (hex_out !== exp_hex(0) || busy !== 1'b0 || update !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: hex=%h busy=%b upd=%b ovf=%b, expected hex=%h 0 0 0",
               hex_out, busy, update, overflow, exp_hex(0));
    end
    @(posedge clock); #1;
    reset = 1'b0;
    wait_upd(n);
    n_tests++;
    if (n !== 34 || hex_out !== exp_hex(777) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL recapture_777: edges=%0d hex=%h ovf=%b, expected 34 %h 0",
               n, hex_out, overflow, exp_hex(777));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_blanking();
    convert_and_check(42, "blank_42");
    convert_and_check(0, "blank_zero");
    convert_and_check(100200, "inner_zeros");
  endtask

  initial begin
    reset = 1'b1;
    port_in = '0;
    test_reset();
    test_convert_timing();
    test_overflow();
    test_busy_changes();
    test_random();
    test_reset_midconv();
    test_blanking();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
